// File: rtl/vga_pkg.sv
// Shared timing constants and counter widths for the 800x600@60 video pipeline.
// Downstream delay and draw stages import the same widths from here.
package vga_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    localparam int VGA_H_VISIBLE = 800;
    localparam int VGA_H_FRONT   = 40;
    localparam int VGA_H_SYNC    = 128;
    localparam int VGA_H_BACK    = 88;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 600;
    localparam int VGA_V_FRONT   = 1;
    localparam int VGA_V_SYNC    = 4;
    localparam int VGA_V_BACK    = 23;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Sync windows are half-open: [START, END)
    localparam int VGA_HSYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int VGA_HSYNC_END   = VGA_HSYNC_START + VGA_H_SYNC;
    localparam int VGA_VSYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int VGA_VSYNC_END   = VGA_VSYNC_START + VGA_V_SYNC;

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: counters, blanking, syncs and frame-start pulse,
// all registered together so the flags always describe the counts of the same cycle.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                hblnk_out,
    output logic                vblnk_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                frame_start_out
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > (1 << HCOUNT_W)) begin : g_htotal_chk
        $error("H_TOTAL does not fit in HCOUNT_W bits");
    end
    if (V_TOTAL > (1 << VCOUNT_W)) begin : g_vtotal_chk
        $error("V_TOTAL does not fit in VCOUNT_W bits");
    end

    localparam logic [HCOUNT_W-1:0] H_LAST     = HCOUNT_W'(H_TOTAL - 1);
    localparam logic [VCOUNT_W-1:0] V_LAST     = VCOUNT_W'(V_TOTAL - 1);
    localparam logic [HCOUNT_W-1:0] H_BLNK     = HCOUNT_W'(H_VISIBLE);
    localparam logic [VCOUNT_W-1:0] V_BLNK     = VCOUNT_W'(V_VISIBLE);
    localparam logic [HCOUNT_W-1:0] HS_START   = HCOUNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [HCOUNT_W-1:0] HS_END     = HCOUNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VCOUNT_W-1:0] VS_START   = VCOUNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [VCOUNT_W-1:0] VS_END     = VCOUNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HCOUNT_W-1:0] hcount_q, hcount_d;
    logic [VCOUNT_W-1:0] vcount_q, vcount_d;
    logic                hblnk_q, hblnk_d;
    logic                vblnk_q, vblnk_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                fstart_q, fstart_d;

    // Flags are derived from the next counts so they land in the same register stage.
    always_comb begin
        hcount_d = hcount_q + HCOUNT_W'(1);
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VCOUNT_W'(1);
        end
        hblnk_d  = (hcount_d >= H_BLNK);
        vblnk_d  = (vcount_d >= V_BLNK);
        hsync_d  = ((hcount_d >= HS_START) && (hcount_d < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d  = ((vcount_d >= VS_START) && (vcount_d < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        fstart_d = (hcount_d == '0) && (vcount_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            fstart_q <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            fstart_q <= fstart_d;
        end
    end

    assign hcount_out      = hcount_q;
    assign vcount_out      = vcount_q;
    assign hblnk_out       = hblnk_q;
    assign vblnk_out       = vblnk_q;
    assign hsync_out       = hsync_q;
    assign vsync_out       = vsync_q;
    assign frame_start_out = fstart_q;

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running VGA raster generator producing the horizontal/vertical pixel counters, blanking flags and sync pulses for an 800x600 @ 60 Hz display with a 40 MHz pixel clock. It is the first stage of the video pipeline and feeds the GUI delay-alignment stage and the drawing stages directly. All outputs are registered and mutually aligned: the flags in any cycle describe the counter values presented in that same cycle.

## Interface
Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BACK, 88, horizontal back porch (pixels); H_TOTAL = 1056
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BACK, 23, vertical back porch (lines); V_TOTAL = 628
- HSYNC_POL, 1, active level of hsync_out (1 = active-high)
- VSYNC_POL, 1, active level of vsync_out

Ports:
- clk  in  1  pixel clock, 40 MHz
- rst  in  1  reset, synchronous, active-high
- hcount_out  out  11  horizontal position, 0..H_TOTAL-1
- vcount_out  out  10  vertical position, 0..V_TOTAL-1
- hblnk_out  out  1  high while hcount_out >= H_VISIBLE
- vblnk_out  out  1  high while vcount_out >= V_VISIBLE
- hsync_out  out  1  active while H_VISIBLE+H_FRONT <= hcount_out < H_VISIBLE+H_FRONT+H_SYNC
- vsync_out  out  1  active while V_VISIBLE+V_FRONT <= vcount_out < V_VISIBLE+V_FRONT+V_SYNC
- frame_start_out  out  1  one-cycle pulse when hcount_out==0 and vcount_out==0

## Operation
- Horizontal counter increments every cycle; at H_TOTAL-1 it wraps to 0 and the vertical counter advances.
- Vertical counter wraps from V_TOTAL-1 to 0 on the same edge as the horizontal wrap at hcount H_TOTAL-1.
- No enable input; generator never stalls.
- Flags and frame_start computed combinationally from the next counter values and registered together with the counters, so they never lag the counts by a cycle.
- Default constants: hblnk 800..1055, hsync 840..967, vblnk 600..627, vsync 601..604.
- Counter arithmetic in full 11/10-bit width; compile-time check that H_TOTAL <= 2048 and V_TOTAL <= 1024.

## Timing
- Reset (edge with rst=1): hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0, hsync_out=~HSYNC_POL, vsync_out=~VSYNC_POL, frame_start_out=0.
- First edge with rst=0: hcount_out=1, vcount_out=0; counting proceeds from there.
- frame_start_out is not asserted for the reset state; first pulse coincides with the first wrap to (0,0), H_TOTAL*V_TOTAL-1 = 663167 cycles after the first non-reset edge.
- Reset asserted mid-frame: outputs return to the reset values on that edge regardless of position; no partial-line completion.
- Line period 1056 cycles (26.4 us); frame period 663168 cycles (16.58 ms).
- Latency from counter to flag: 0 cycles (same-cycle alignment is an invariant checked by the bench).

## Structure
- Shared package vga_pkg: all default timing constants (visible, porch, sync, totals), derived sync start/end values, and counter widths (HCOUNT_W=11, VCOUNT_W=10); the downstream delay and draw stages import the same widths.
- Single module; no sub-module needed — the two counters are small and share one wrap condition.

## Test plan
- Hold rst 5 cycles, release -> all outputs at reset values during reset; hcount_out=1, vcount_out=0 on first free edge.
- Run one full line -> hcount 799 hblnk=0, 800 hblnk=1; hsync active exactly at 840..967 (128 cycles); hcount 1055 followed by 0 with vcount incremented.
- Run one full frame -> vblnk rises at vcount 600; vsync active for lines 601..604 (4*1056 cycles); vcount 627 at hcount 1055 wraps to (0,0) with frame_start_out=1 for exactly one cycle.
- Two consecutive frames -> frame_start pulses spaced exactly 663168 cycles; every cycle the flags match the range predicates of the presented counts.
- Assert rst at hcount=500, vcount=300 for 1 cycle -> next outputs all reset values, counting resumes at hcount=1, vcount=0.
- Instantiate with HSYNC_POL=0, VSYNC_POL=0 -> syncs idle high, low only within the sync ranges; high during reset.
